ioshim_regfile: RTL and testbench

Parametrised multi-read-port register file for the ioshim datapath. It is the next-generation register file: configurable data width, depth and read-port count, with masked writes and write-to-read forwarding. It also has a hardware clear sequencer that sweeps every entry to a reset value after reset or on request, and a per-entry dirty map. It sits between the ioshim instruction decoder (read ports) and the writeback stage (write port).

---
 rtl/ioshim_pkg.sv | 12 +
 rtl/ioshim_regfile_clr.sv | 64 ++++++
 rtl/ioshim_regfile.sv | 97 +++++++++
 tb/tb_ioshim_regfile.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ioshim_pkg.sv
// Shared types and default widths for the ioshim register file.
package ioshim_pkg;

  localparam int unsigned IOSHIM_DATA_W = 8;
  localparam int unsigned IOSHIM_ADDR_W = 4;

  typedef enum logic [0:0] {
    ST_CLEAR,
    ST_IDLE
  } state_e;

endpackage

// File: rtl/ioshim_regfile_clr.sv
// Clear sequencer: sweeps every entry once after reset or on request.
module ioshim_regfile_clr
  import ioshim_pkg::*;
#(
  parameter int unsigned ADDR_W = IOSHIM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  output logic              busy,
  output logic              idle,
  output logic              sweep_we,
  output logic [ADDR_W-1:0] sweep_addr
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  // State and sweep pointer; reset restarts the sweep from entry 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state: walk the pointer to the last entry, then idle until asked to clear again.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == '1) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end
      end
      ST_IDLE: begin
        // A request mid-sweep never reaches here, so it is ignored by construction.
        if (clear_req) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  // Status and sweep strobe decoded from the current state.
  always_comb begin
    busy       = (state_q == ST_CLEAR);
    idle       = (state_q == ST_IDLE);
    sweep_we   = busy;
    sweep_addr = ptr_q;
  end

endmodule

// File: rtl/ioshim_regfile.sv
// Multi-read-port register file with masked writes, write-to-read forwarding,
// hardware clear sweep and per-entry dirty map.
module ioshim_regfile
  import ioshim_pkg::*;
#(
  parameter int unsigned       DATA_W    = IOSHIM_DATA_W,
  parameter int unsigned       ADDR_W    = IOSHIM_ADDR_W,
  parameter int unsigned       NRD       = 2,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_req,
  output logic                  busy,
  input  logic                  wr_en,
  output logic                  wr_ready,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W-1:0]     wr_mask,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [2**ADDR_W-1:0]  dirty
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic              idle;
  logic              sweep_we;
  logic [ADDR_W-1:0] sweep_addr;
  logic              wr_fire;
  logic [DATA_W-1:0] wr_merged;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  dirty_q;

  ioshim_regfile_clr #(
    .ADDR_W(ADDR_W)
  ) u_clr (
    .clk       (clk),
    .reset     (reset),
    .clear_req (clear_req),
    .busy      (busy),
    .idle      (idle),
    .sweep_we  (sweep_we),
    .sweep_addr(sweep_addr)
  );

  // Write handshake and bit-masked merge against the current entry contents.
  always_comb begin
    wr_ready  = idle && !clear_req;
    wr_fire   = wr_en && wr_ready;
    wr_merged = (mem_q[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
  end

  // Storage array: no reset, the sweep initialises it. Sweep and writes never overlap.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem_q[sweep_addr] <= RESET_VAL;
    end else if (wr_fire) begin
      mem_q[wr_addr] <= wr_merged;
    end
  end

  // Dirty map: cleared by reset and by the sweep, set by any accepted write (even mask 0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dirty_q <= '0;
    end else if (sweep_we) begin
      dirty_q[sweep_addr] <= 1'b0;
    end else if (wr_fire) begin
      dirty_q[wr_addr] <= 1'b1;
    end
  end

  assign dirty = dirty_q;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] val;

    assign addr = rd_addr[i*ADDR_W +: ADDR_W];

    // Read mux: reset value while sweeping, forwarded merge on a same-cycle write hit.
    always_comb begin
      if (busy) begin
        val = RESET_VAL;
      end else if (wr_fire && (wr_addr == addr)) begin
        val = wr_merged;
      end else begin
        val = mem_q[addr];
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = val;
  end

endmodule

// File: tb/tb_ioshim_regfile.sv
// Self-checking bench for ioshim_regfile: default config plus a wide 4-port config.
module tb_ioshim_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear_req;
  logic        busy;
  logic        wr_en;
  logic        wr_ready;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [7:0]  wr_mask;
  logic [7:0]  rd_addr;
  logic [15:0] rd_data;
  logic [15:0] dirty;

  logic        reset2;
  logic        clear_req2;
  logic        busy2;
  logic        wr_en2;
  logic        wr_ready2;
  logic [1:0]  wr_addr2;
  logic [15:0] wr_data2;
  logic [15:0] wr_mask2;
  logic [7:0]  rd_addr2;
  logic [63:0] rd_data2;
  logic [3:0]  dirty2;

  int n_cmp;
  int n_fail;

  // Reference model of the default instance.
  logic [7:0]  m_mem [16];
  logic [15:0] m_dirty;
  int          m_left;  // sweep cycles still to run; busy while nonzero

  always #5 clk = ~clk;

  ioshim_regfile dut (
    .clk      (clk),
    .reset    (reset),
    .clear_req(clear_req),
    .busy     (busy),
    .wr_en    (wr_en),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_mask  (wr_mask),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .dirty    (dirty)
  );

  ioshim_regfile #(
    .DATA_W   (16),
    .ADDR_W   (2),
    .NRD      (4),
    .RESET_VAL(16'h00C3)
  ) dut2 (
    .clk      (clk),
    .reset    (reset2),
    .clear_req(clear_req2),
    .busy     (busy2),
    .wr_en    (wr_en2),
    .wr_ready (wr_ready2),
    .wr_addr  (wr_addr2),
    .wr_data  (wr_data2),
    .wr_mask  (wr_mask2),
    .rd_addr  (rd_addr2),
    .rd_data  (rd_data2),
    .dirty    (dirty2)
  );

  function automatic logic [7:0] exp_rd(input logic [3:0] a);
    if (m_left > 0) return 8'h00;
    if (wr_en && !clear_req && (a == wr_addr)) return (m_mem[a] & ~wr_mask) | (wr_data & wr_mask);
    return m_mem[a];
  endfunction

  // Advance one clock and apply the same-edge effect to the model.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_left  = 16;
      m_dirty = '0;
    end else if (m_left > 0) begin
      m_mem[16 - m_left]   = 8'h00;
      m_dirty[16 - m_left] = 1'b0;
      m_left--;
    end else if (clear_req) begin
      m_left = 16;
    end else if (wr_en) begin
      m_mem[wr_addr]   = (m_mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
      m_dirty[wr_addr] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    int cnt;
    reset   = 1'b1;
    m_left  = 16;
    m_dirty = '0;
    rd_addr = 8'($urandom);
    #1;
    n_cmp++;
    if (busy !== 1'b1 || wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: busy=%b wr_ready=%b want busy=1 wr_ready=0", busy, wr_ready);
    end
    n_cmp++;
    if (dirty !== 16'h0000 || rd_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_outputs: dirty=%h rd_data=%h want 0000/0000", dirty, rd_data);
    end
    tick();
    tick();
    reset = 1'b0;
    cnt   = 0;
    while (busy === 1'b1 && cnt < 40) begin
      rd_addr = 8'($urandom);
      #1;
      n_cmp++;
      if (rd_data !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_sweep_rd: got %h want 0000", rd_data);
      end
      tick();
      cnt++;
    end
    n_cmp++;
    if (cnt != 16) begin
      n_fail++;
      $display("FAIL reset_sweep_len: got %0d cycles want 16", cnt);
    end
    n_cmp++;
    if (dirty !== 16'h0000 || wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_done: dirty=%h wr_ready=%b want 0000/1", dirty, wr_ready);
    end
  endtask

  task automatic test_write_fwd();
    wr_en   = 1'b1;
    wr_addr = 4'd3;
    wr_data = 8'hA5;
    wr_mask = 8'hFF;
    rd_addr = {4'd7, 4'd3};
    #1;
    n_cmp++;
    if (wr_ready !== 1'b1 || rd_data[7:0] !== 8'hA5) begin
      n_fail++;
      $display("FAIL write_fwd: wr_ready=%b rd0=%h want 1/a5", wr_ready, rd_data[7:0]);
    end
    tick();
    wr_en = 1'b0;
    #1;
    n_cmp++;
    if (rd_data[7:0] !== 8'hA5 || dirty[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL write_stored: rd0=%h dirty3=%b want a5/1", rd_data[7:0], dirty[3]);
    end
  endtask

  task automatic test_masked();
    wr_en   = 1'b1;
    wr_addr = 4'd3;
    wr_data = 8'h0F;
    wr_mask = 8'h0F;
    rd_addr = {4'd3, 4'd3};
    #1;
    n_cmp++;
    if (rd_data !== 16'hAFAF) begin
      n_fail++;
      $display("FAIL masked_fwd: got %h want afaf", rd_data);
    end
    tick();
    wr_en = 1'b0;
    #1;
    n_cmp++;
    if (rd_data !== 16'hAFAF) begin
      n_fail++;
      $display("FAIL masked_stored: got %h want afaf", rd_data);
    end
  endtask

  task automatic test_clear_vs_write();
    int cnt;
    clear_req = 1'b1;
    wr_en     = 1'b1;
    wr_addr   = 4'd5;
    wr_data   = 8'h3C;
    wr_mask   = 8'hFF;
    rd_addr   = {4'd5, 4'd5};
    #1;
    n_cmp++;
    if (wr_ready !== 1'b0 || rd_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL clear_block: wr_ready=%b rd=%h want 0/0000", wr_ready, rd_data);
    end
    tick();
    clear_req = 1'b0;
    wr_en     = 1'b0;
    cnt       = 0;
    while (busy === 1'b1 && cnt < 40) begin
      clear_req = (cnt == 5);  // must not restart the sweep
      tick();
      cnt++;
    end
    clear_req = 1'b0;
    #1;
    n_cmp++;
    if (cnt != 16) begin
      n_fail++;
      $display("FAIL clear_len: got %0d cycles want 16", cnt);
    end
    n_cmp++;
    if (rd_data !== 16'h0000 || dirty !== 16'h0000) begin
      n_fail++;
      $display("FAIL clear_result: rd=%h dirty=%h want 0000/0000", rd_data, dirty);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int cnt;
    wr_en   = 1'b1;
    wr_mask = 8'hFF;
    wr_addr = 4'd1;
    wr_data = 8'h11;
    tick();
    wr_addr = 4'd12;
    wr_data = 8'hC7;
    tick();
    wr_en     = 1'b0;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    reset   = 1'b1;
    m_left  = 16;
    m_dirty = '0;
    #1;
    n_cmp++;
    if (busy !== 1'b1 || dirty !== 16'h0000) begin
      n_fail++;
      $display("FAIL midreset_async: busy=%b dirty=%h want 1/0000", busy, dirty);
    end
    tick();
    reset = 1'b0;
    cnt   = 0;
    while (busy === 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
    n_cmp++;
    if (cnt != 16) begin
      n_fail++;
      $display("FAIL midreset_len: got %0d cycles want 16", cnt);
    end
    for (int a = 0; a < 16; a += 2) begin
      rd_addr = {4'(a + 1), 4'(a)};
      #1;
      n_cmp++;
      if (rd_data !== 16'h0000) begin
        n_fail++;
        $display("FAIL midreset_rd: addr %0d got %h want 0000", a, rd_data);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] a;
    for (int c = 0; c < 400; c++) begin
      wr_en     = 1'($urandom);
      wr_addr   = 4'($urandom);
      wr_data   = 8'($urandom);
      wr_mask   = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      clear_req = ($urandom_range(0, 59) == 0);
      rd_addr   = ($urandom_range(0, 2) == 0) ? {wr_addr, wr_addr} : 8'($urandom);
      #1;
      n_cmp++;
      if (busy !== (m_left > 0) || wr_ready !== (m_left == 0 && !clear_req)) begin
        n_fail++;
        $display("FAIL rand_status: cyc %0d busy=%b wr_ready=%b want %b/%b", c, busy, wr_ready,
                 (m_left > 0), (m_left == 0 && !clear_req));
      end
      n_cmp++;
      if (dirty !== m_dirty) begin
        n_fail++;
        $display("FAIL rand_dirty: cyc %0d got %h want %h", c, dirty, m_dirty);
      end
      for (int p = 0; p < 2; p++) begin
        a = rd_addr[p*4 +: 4];
        n_cmp++;
        if (rd_data[p*8 +: 8] !== exp_rd(a)) begin
          n_fail++;
          $display("FAIL rand_rd: cyc %0d port %0d addr %0d got %h want %h", c, p, a,
                   rd_data[p*8 +: 8], exp_rd(a));
        end
      end
      tick();
    end
    wr_en     = 1'b0;
    clear_req = 1'b0;
  endtask

  task automatic test_wide();
    int cnt;
    rd_addr2 = {2'd3, 2'd2, 2'd1, 2'd0};
    #1;
    n_cmp++;
    if (busy2 !== 1'b1 || rd_data2 !== {4{16'h00C3}}) begin
      n_fail++;
      $display("FAIL wide_reset: busy=%b rd=%h want 1/00c3x4", busy2, rd_data2);
    end
    reset2 = 1'b0;
    cnt    = 0;
    while (busy2 === 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
    n_cmp++;
    if (cnt != 4) begin
      n_fail++;
      $display("FAIL wide_sweep_len: got %0d cycles want 4", cnt);
    end
    wr_en2   = 1'b1;
    wr_data2 = 16'h1234;
    wr_mask2 = 16'hFFFF;
    for (int a = 0; a < 4; a++) begin
      wr_addr2 = 2'(a);
      tick();
    end
    wr_en2 = 1'b0;
    #1;
    n_cmp++;
    if (rd_data2 !== {4{16'h1234}} || dirty2 !== 4'hF) begin
      n_fail++;
      $display("FAIL wide_rd: rd=%h dirty=%h want 1234x4/f", rd_data2, dirty2);
    end
    wr_en2   = 1'b1;
    wr_addr2 = 2'd2;
    wr_data2 = 16'hAB00;
    wr_mask2 = 16'hFF00;
    #1;
    n_cmp++;
    if (rd_data2[47:32] !== 16'hAB34 || rd_data2[31:16] !== 16'h1234) begin
      n_fail++;
      $display("FAIL wide_masked: p2=%h p1=%h want ab34/1234", rd_data2[47:32], rd_data2[31:16]);
    end
    tick();
    wr_en2 = 1'b0;
  endtask

  initial begin
    n_cmp      = 0;
    n_fail     = 0;
    reset      = 1'b1;
    reset2     = 1'b1;
    clear_req  = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    wr_mask    = '0;
    rd_addr    = '0;
    clear_req2 = 1'b0;
    wr_en2     = 1'b0;
    wr_addr2   = '0;
    wr_data2   = '0;
    wr_mask2   = '0;
    rd_addr2   = '0;
    m_left     = 16;
    m_dirty    = '0;
    @(negedge clk);
    test_reset();
    test_write_fwd();
    test_masked();
    test_clear_vs_write();
    test_reset_mid_sweep();
    test_random();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
